// File: rtl/battlefield_pkg.sv
// Shared constants for the battlefield background path (index fetch and palette stage).
package battlefield_pkg;

  localparam int IMG_W_DEFAULT  = 320;
  localparam int IMG_H_DEFAULT  = 240;
  localparam int ADDR_W_DEFAULT = 17;

  localparam int COORD_W  = 10;
  localparam int SCROLL_W = 9;

  // Screen coordinate that marks the first pixel of a new frame
  localparam logic [COORD_W-1:0] FRAME_START_X = '0;
  localparam logic [COORD_W-1:0] FRAME_START_Y = '0;

endpackage

// File: rtl/bg_addr_calc.sv
// Combinational ROM address generator: addr = sy * IMG_W + sx using shifts and adds only.
module bg_addr_calc
  import battlefield_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [COORD_W-1:0]  sx,
  input  logic [COORD_W-2:0]  sy,
  output logic [ADDR_W-1:0]   addr
);

  // Sum one shifted copy of sy per set bit of the constant width (320 = 256 + 64)
  always_comb begin
    addr = ADDR_W'(sx);
    for (int k = 0; k < 32; k++) begin
      if (IMG_W[k]) begin
        addr = addr + (ADDR_W'(sy) << k);
      end
    end
  end

endmodule

// File: rtl/battlefield_index_fetch.sv
// Three-stage pixel pipeline turning screen coordinates into background palette indices,
// with a horizontal scroll that is staged and only takes effect at frame start.
module battlefield_index_fetch
  import battlefield_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEFAULT,
  parameter int IMG_H  = IMG_H_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 in_valid,
  input  logic [COORD_W-1:0]   DrawX,
  input  logic [COORD_W-1:0]   DrawY,
  input  logic                 blank,
  input  logic [SCROLL_W-1:0]  scroll_x,
  input  logic                 scroll_load,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [3:0]           rom_data,
  output logic [3:0]           index,
  output logic                 index_valid,
  output logic                 scroll_err
);

  localparam logic [COORD_W-1:0] IMG_W_C = COORD_W'(IMG_W);

  logic [COORD_W-1:0]  a_x;
  logic [COORD_W-1:0]  a_y;
  logic                a_blank;
  logic                a_valid;

  logic                b_blank;
  logic                b_valid;

  logic [SCROLL_W-1:0] pending_scroll;
  logic [SCROLL_W-1:0] active_scroll;

  logic                frame_start;
  logic [COORD_W-1:0]  sx_sum;
  logic [COORD_W-1:0]  sx;
  logic [COORD_W-2:0]  sy;
  logic [ADDR_W-1:0]   addr_next;

  // The pixel LSBs vanish in the 2x upscale; IMG_H only documents the ROM extent
  logic unused_bits;
  assign unused_bits = ^{a_x[0], a_y[0], IMG_H[0]};

  assign frame_start = in_valid && (DrawX == FRAME_START_X) && (DrawY == FRAME_START_Y);

  // Stage A: capture the incoming pixel strobe and coordinates
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_x     <= '0;
      a_y     <= '0;
      a_blank <= 1'b0;
      a_valid <= 1'b0;
    end else begin
      a_x     <= DrawX;
      a_y     <= DrawY;
      a_blank <= blank;
      a_valid <= in_valid;
    end
  end

  // Scroll staging: active copy moves at the same edge the frame-start pixel enters stage A,
  // so it already applies to that pixel in stage B and sees the pre-load pending value
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending_scroll <= '0;
      active_scroll  <= '0;
      scroll_err     <= 1'b0;
    end else begin
      if (scroll_load) begin
        if ({1'b0, scroll_x} < IMG_W_C) begin
          pending_scroll <= scroll_x;
        end else begin
          scroll_err <= 1'b1;
        end
      end
      if (frame_start) begin
        active_scroll <= pending_scroll;
      end
    end
  end

  // Stage B coordinate mapping: halve screen coords, add scroll, wrap once at the image width
  always_comb begin
    sx_sum = {1'b0, a_x[COORD_W-1:1]} + {1'b0, active_scroll};
    sx     = sx_sum;
    if (sx_sum >= IMG_W_C) begin
      sx = sx_sum - IMG_W_C;
    end
    sy = a_y[COORD_W-1:1];
  end

  bg_addr_calc #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .sx   (sx),
    .sy   (sy),
    .addr (addr_next)
  );

  // Stage B: register the ROM address every cycle, bubbles included
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      b_blank  <= 1'b0;
      b_valid  <= 1'b0;
    end else begin
      rom_addr <= addr_next;
      b_blank  <= a_blank;
      b_valid  <= a_valid;
    end
  end

  // Stage C: take the ROM data, forcing index 0 outside the visible region
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      index       <= 4'h0;
      index_valid <= 1'b0;
    end else begin
      index       <= b_blank ? rom_data : 4'h0;
      index_valid <= b_valid;
    end
  end

endmodule

// File: doc/battlefield_index_fetch.md
BATTLEFIELD_INDEX_FETCH -- requirements
Module: battlefield_index_fetch

Interface
REQ-001 SHALL have parameters: IMG_W, default 320, stored image width in pixels; IMG_H, default 240, stored image height in pixels; ADDR_W, default 17, ROM address width.
REQ-002 Clk  input  1  system clock; all state on rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  pixel strobe; DrawX/DrawY/blank are valid this cycle.
REQ-005 DrawX  input  10  screen column, 0..639.
REQ-006 DrawY  input  10  screen row, 0..479.
REQ-007 blank  input  1  high = visible region, low = blanking.
REQ-008 scroll_x  input  9  requested horizontal scroll in stored pixels.
REQ-009 scroll_load  input  1  one-cycle request to stage scroll_x.
REQ-010 rom_addr  output  ADDR_W  address to the background ROM (registered read, 1-cycle latency).
REQ-011 rom_data  input  4  ROM palette index returned one clock after rom_addr.
REQ-012 index  output  4  palette index for the downstream battlefield palette lookup.
REQ-013 index_valid  output  1  index is valid this cycle.
REQ-014 scroll_err  output  1  sticky: a scroll_load carried scroll_x >= IMG_W.

Function
REQ-015 SHALL be a 3-stage pipeline advancing every Clk with no stalls; index_valid SHALL equal in_valid delayed exactly 3 cycles.
REQ-016 Stage A SHALL register DrawX, DrawY, blank and in_valid.
REQ-017 Stage B SHALL compute sx = (DrawX>>1) + active_scroll, wrapping with sx >= IMG_W -> sx - IMG_W, and sy = DrawY>>1.
REQ-018 Stage B SHALL register rom_addr = sy*IMG_W + sx, built from shifts/adds only (320 = 256 + 64), no multiplier.
REQ-019 Stage C SHALL register index = rom_data when the stage-B blank bit is 1, else 4'h0.
REQ-020 Stage C SHALL register index_valid from the stage-B valid bit.
REQ-021 When scroll_load = 1 and scroll_x < IMG_W, the block SHALL store scroll_x in pending_scroll.
REQ-022 When scroll_load = 1 and scroll_x >= IMG_W, pending_scroll SHALL be unchanged and scroll_err SHALL be set (cleared only by reset).
REQ-023 A frame-start event SHALL be defined as in_valid = 1 with DrawX = 0 and DrawY = 0.
REQ-024 On a frame-start event, active_scroll SHALL load pending_scroll, and that new value SHALL apply to that same pixel in stage B; scroll never changes mid-frame.
REQ-025 When scroll_load and frame-start occur in the same cycle, active_scroll SHALL take the old pending value; the new value SHALL apply from the next frame.
REQ-026 Stage-B bubbles (valid = 0) SHALL still update rom_addr; only valid bits gate index_valid.
REQ-027 Coordinates beyond 639/479 SHALL be masked only by blank; no extra range check.

Reset
REQ-028 While Reset_n = 0, all pipeline registers, rom_addr, index and index_valid SHALL be 0.
REQ-029 While Reset_n = 0, pending_scroll, active_scroll and scroll_err SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard in-flight pixels, with no index_valid pulse after release until 3 cycles after the next in_valid.

Structure
REQ-031 IMG_W, IMG_H, ADDR_W and the frame-start coordinate constants SHALL live in shared package battlefield_pkg, imported by this block and the palette stage.
REQ-032 Address arithmetic SHALL be one combinational sub-module, bg_addr_calc (inputs sx, sy; output address), instantiated in stage B.

Verification
REQ-033 Scroll 0, DrawX=10, DrawY=6, blank=1 -> rom_addr = 965 at cycle 2; index = rom_data and index_valid = 1 at cycle 3.
REQ-034 Load scroll 100, then frame start, then DrawX=600, DrawY=0 -> sx = 400 - 320 = 80, rom_addr = 80.
REQ-035 scroll_load with scroll_x = 320 -> scroll_err = 1 and pending_scroll unchanged; next frame keeps the prior scroll.
REQ-036 blank = 0 with rom_data = 4'hA -> index = 0, index_valid = 1.
REQ-037 scroll_load = 50 coincident with frame start, prior pending = 20 -> that frame uses 20, the next frame uses 50.
REQ-038 Reset_n pulsed low during a 3-pixel burst -> all outputs 0 immediately; no index_valid until 3 cycles after the first post-reset in_valid.
